// File: rtl/enemy_ai_pkg.sv
// Shared types for the enemy AI: action/state enums, the output strobe bundle
// and the action-to-strobe decode.
package enemy_ai_pkg;

  typedef enum logic [2:0] {
    NONE, MOVE_R, MOVE_L, JUMP, SQUAT, ATTACK, DEFEND
  } ai_action_t;

  typedef enum logic [1:0] {
    S_IDLE, S_DECIDE, S_HOLD
  } ai_state_t;

  localparam logic [15:0] AI_LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic right;
    logic left;
    logic jump;
    logic squat;
    logic attack;
    logic defend;
  } ai_out_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // jump and attack are strobes: only driven on the first cycle of a hold
  function automatic ai_out_t act_to_out(input ai_action_t a, input logic first);
    ai_out_t o;
    o = '0;
    case (a)
      MOVE_R:  o.right  = 1'b1;
      MOVE_L:  o.left   = 1'b1;
      JUMP:    o.jump   = first;
      SQUAT:   o.squat  = 1'b1;
      ATTACK:  o.attack = first;
      DEFEND:  o.defend = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with reload on the all-zero lock-up state.
module lfsr16
  import enemy_ai_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    if (lfsr_q == 16'h0000) lfsr_d = seed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= seed;
    else        lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/enemy_ai.sv
// Enemy control strobes: a step-paced pseudo-random decide/hold FSM that
// defends whenever the player's bullet comes within DODGE_DIST.
module enemy_ai
  import enemy_ai_pkg::*;
#(
  parameter int          STEP_CYCLES           = 833333,
  parameter int          HOLD_MIN_STEPS        = 4,
  parameter int          ATTACK_COOLDOWN_STEPS = 16,
  parameter int          DODGE_DIST            = 96,
  parameter logic [15:0] LFSR_SEED             = AI_LFSR_SEED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  input  logic signed [10:0] i_enemy_x,
  input  logic signed [10:0] i_player_x,
  input  logic signed [10:0] i_goodbullet_x,
  input  logic               i_goodbullet_isE,
  output logic               o_right,
  output logic               o_left,
  output logic               o_jump,
  output logic               o_squat,
  output logic               o_attack,
  output logic               o_defend
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_MIN_STEPS + 8);
  localparam int CW = (ATTACK_COOLDOWN_STEPS > 1) ? $clog2(ATTACK_COOLDOWN_STEPS + 1) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MIN  = HW'(HOLD_MIN_STEPS);
  localparam logic [CW-1:0] COOL_LOAD = CW'(ATTACK_COOLDOWN_STEPS);

  ai_state_t     state_q, state_d;
  ai_action_t    act_q, act_d, pick, toward, away;
  ai_out_t       out_q, out_d;
  logic [SW-1:0] step_q, step_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [15:0]   lfsr;
  logic          step_tick, dodge;
  logic signed [11:0] dx;
  logic [11:0]        adx;
  logic               unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .out   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:6];

  // 12-bit difference cannot overflow for any pair of 11-bit positions
  assign dx    = {i_goodbullet_x[10], i_goodbullet_x} - {i_enemy_x[10], i_enemy_x};
  assign adx   = dx[11] ? 12'(-dx) : 12'(dx);
  assign dodge = i_goodbullet_isE && (adx <= 12'(DODGE_DIST));

  assign step_tick = (state_q != S_IDLE) && (step_q == STEP_LAST);

  always_comb begin
    toward = NONE;
    away   = NONE;
    if (i_player_x > i_enemy_x) begin
      toward = MOVE_R;
      away   = MOVE_L;
    end else if (i_player_x < i_enemy_x) begin
      toward = MOVE_L;
      away   = MOVE_R;
    end
  end

  always_comb begin
    pick = NONE;
    if (dodge) pick = DEFEND;
    else begin
      case (lfsr[2:0])
        3'd0, 3'd1: pick = toward;
        3'd2:       pick = away;
        3'd3:       pick = JUMP;
        3'd4:       pick = SQUAT;
        3'd5, 3'd6: pick = (cool_q == '0) ? ATTACK : NONE;
        default:    pick = NONE;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    hold_d  = hold_q;
    cool_d  = cool_q;
    out_d   = '0;
    step_d  = '0;
    if (state_q != S_IDLE) step_d = step_tick ? '0 : step_q + 1'b1;
    if (step_tick && (cool_q != '0)) cool_d = cool_q - 1'b1;

    case (state_q)
      S_IDLE: if (i_enable) state_d = S_DECIDE;
      S_DECIDE: begin
        act_d   = pick;
        hold_d  = HOLD_MIN + HW'(lfsr[5:3]);
        state_d = S_HOLD;
        out_d   = act_to_out(pick, 1'b1);
        if (pick == ATTACK) cool_d = COOL_LOAD;
      end
      S_HOLD: begin
        // a threatening bullet overrides the remaining hold time
        if (dodge && (act_q != DEFEND)) state_d = S_DECIDE;
        else if (step_tick) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HW'(1)) state_d = S_DECIDE;
        end
        if (state_d == S_HOLD) out_d = act_to_out(act_q, 1'b0);
      end
      default: state_d = S_IDLE;
    endcase

    if (!i_enable) begin
      state_d = S_IDLE;
      act_d   = NONE;
      hold_d  = '0;
      cool_d  = '0;
      step_d  = '0;
      out_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      act_q   <= NONE;
      step_q  <= '0;
      hold_q  <= '0;
      cool_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      cool_q  <= cool_d;
      out_q   <= out_d;
    end
  end

  assign o_right  = out_q.right;
  assign o_left   = out_q.left;
  assign o_jump   = out_q.jump;
  assign o_squat  = out_q.squat;
  assign o_attack = out_q.attack;
  assign o_defend = out_q.defend;

endmodule
